// File: rtl/mult_sequencer_pkg.sv
// Shared encodings and constants for the operator-driven multiplier sequencer.
// No logic lives here: state codes, the error word and the display word width.
package mult_sequencer_pkg;

  localparam logic [2:0] ST_GET_A = 3'd0;
  localparam logic [2:0] ST_GET_B = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;

  typedef enum logic [2:0] {
    S_GET_A = ST_GET_A,
    S_GET_B = ST_GET_B,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_SHOW  = ST_SHOW
  } state_e;

  localparam logic [15:0] ERR_CODE_DEFAULT = 16'hEEEE;
  localparam int          DISP_W           = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, registered rising-edge pulse.
// press_o rises 2 + DEB_CYCLES + 1 cycles after a clean button rise; release emits nothing.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mult_sequencer.sv
// Operator sequencer: captures A/B on button presses, launches the multiplier, supervises with a timeout.
// Press in S_GET_B to mul_start is 1 cycle; mul_done to result is 1 cycle; presses while busy are dropped.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int          DEB_CYCLES = 50000,
  parameter int          TIMEOUT    = 1024,
  parameter logic [15:0] ERR_CODE   = ERR_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn,
  input  logic [7:0]        sw,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [15:0]       mul_result,
  output logic [15:0]       result,
  output logic [DISP_W-1:0] disp_value,
  output logic              busy,
  output logic              err
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    mul_a_q, mul_a_d;
  logic [7:0]    mul_b_q, mul_b_d;
  logic [15:0]   result_q, result_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          press;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn),
    .press_o(press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_GET_A;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_GET_A: begin
        if (press) begin
          mul_a_d = sw;
          err_d   = 1'b0;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (press) begin
          mul_b_d = sw;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      // A completion arriving on the expiry cycle still counts as success.
      S_WAIT: begin
        if (mul_done) begin
          result_d = mul_result;
          state_d  = S_SHOW;
        end else if (tmo_q == TMO_MAX) begin
          result_d = ERR_CODE;
          err_d    = 1'b1;
          state_d  = S_SHOW;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (press) begin
          mul_a_d = sw;
          err_d   = 1'b0;
          state_d = S_GET_B;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  always_comb begin
    disp_value = '0;
    unique case (state_q)
      S_GET_A:        disp_value = {8'h00, sw};
      S_GET_B:        disp_value = {mul_a_q, sw};
      S_START,
      S_WAIT:         disp_value = {mul_a_q, mul_b_q};
      S_SHOW:         disp_value = result_q;
      default:        disp_value = '0;
    endcase
  end

  assign mul_start = (state_q == S_START);
  assign busy      = (state_q == S_START) || (state_q == S_WAIT);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with DEB_CYCLES=4, TIMEOUT=16.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic [7:0]  sw;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_start;
  logic        mul_done;
  logic [15:0] mul_result;
  logic [15:0] result;
  logic [15:0] disp_value;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  mult_sequencer #(
    .DEB_CYCLES(4),
    .TIMEOUT   (16),
    .ERR_CODE  (16'hEEEE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .sw        (sw),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_result(mul_result),
    .result    (result),
    .disp_value(disp_value),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mul_start === 1'b1) start_cnt++;

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_btn(input logic [7:0] val);
    sw  = val;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Holds the button until the start pulse is seen (bounded), then releases it.
  task automatic launch(input logic [7:0] val, output bit seen);
    sw   = val;
    btn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; btn = 1'b0; sw = 8'hA5; mul_done = 1'b0; mul_result = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (mul_a !== 8'h00) begin n_fail++; $display("FAIL reset_mul_a: got %h expected 00", mul_a); end
    n_checks++; if (mul_b !== 8'h00) begin n_fail++; $display("FAIL reset_mul_b: got %h expected 00", mul_b); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
    n_checks++; if ({mul_start, busy, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got start/busy/err=%b expected 000", {mul_start, busy, err}); end
    n_checks++; if (disp_value !== 16'h00A5) begin n_fail++; $display("FAIL reset_disp: got %h expected 00a5", disp_value); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bounce();
    int s0;
    s0 = start_cnt;
    sw = 8'h55;
    repeat (5) begin
      btn = 1'b1; repeat (3) @(negedge clk);
      btn = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_checks++; if (mul_a !== 8'h00) begin n_fail++; $display("FAIL bounce_no_capture: mul_a got %h expected 00", mul_a); end
    n_checks++; if (disp_value !== 16'h0055) begin n_fail++; $display("FAIL bounce_state_a: disp got %h expected 0055", disp_value); end
    btn = 1'b1; repeat (4) @(negedge clk);
    btn = 1'b0; repeat (12) @(negedge clk);
    n_checks++; if (mul_a !== 8'h55) begin n_fail++; $display("FAIL bounce_capture: mul_a got %h expected 55", mul_a); end
    n_checks++; if (disp_value !== 16'h5555) begin n_fail++; $display("FAIL bounce_state_b: disp got %h expected 5555", disp_value); end
    n_checks++; if (busy !== 1'b0 || start_cnt != s0) begin n_fail++; $display("FAIL bounce_single: busy=%b starts=%0d expected busy=0 starts=0", busy, start_cnt - s0); end
  endtask

  task automatic test_normal();
    bit seen;
    int s0;
    do_reset();
    s0 = start_cnt;
    press_btn(8'h0C);
    sw = 8'h0A;
    @(negedge clk);
    n_checks++; if (disp_value !== 16'h0C0A) begin n_fail++; $display("FAIL normal_get_b_disp: got %h expected 0c0a", disp_value); end
    launch(8'h0A, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL normal_start_seen: got no start expected start within 20 cycles"); end
    n_checks++; if ({mul_a, mul_b} !== 16'h0C0A) begin n_fail++; $display("FAIL normal_operands: got %h expected 0c0a", {mul_a, mul_b}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL normal_busy_start: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (mul_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL normal_pulse_width: start=%b busy=%b expected 0 1", mul_start, busy); end
    n_checks++; if (disp_value !== 16'h0C0A) begin n_fail++; $display("FAIL normal_wait_disp: got %h expected 0c0a", disp_value); end
    mul_done = 1'b1; mul_result = 16'h0078;
    @(negedge clk);
    mul_done = 1'b0; mul_result = 16'h0000;
    n_checks++; if (result !== 16'h0078) begin n_fail++; $display("FAIL normal_result: got %h expected 0078", result); end
    n_checks++; if (disp_value !== 16'h0078) begin n_fail++; $display("FAIL normal_show_disp: got %h expected 0078", disp_value); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL normal_flags: busy=%b err=%b expected 0 0", busy, err); end
    repeat (10) @(negedge clk);
    n_checks++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL normal_start_count: got %0d expected 1", start_cnt - s0); end
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    press_btn(8'h11);
    n_checks++; if (mul_a !== 8'h11) begin n_fail++; $display("FAIL tmo_capture_a: got %h expected 11", mul_a); end
    launch(8'h22, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL tmo_start_seen: got no start expected start within 20 cycles"); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL tmo_wait_cycles: got %0d expected 16", n); end
    n_checks++; if (result !== 16'hEEEE) begin n_fail++; $display("FAIL tmo_result: got %h expected eeee", result); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err); end
    n_checks++; if (disp_value !== 16'hEEEE) begin n_fail++; $display("FAIL tmo_disp: got %h expected eeee", disp_value); end
    press_btn(8'h33);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b expected 0", err); end
    n_checks++; if (disp_value !== 16'h3333) begin n_fail++; $display("FAIL tmo_recapture: disp got %h expected 3333", disp_value); end
  endtask

  task automatic test_protocol();
    bit seen;
    do_reset();
    press_btn(8'hFF);
    mul_done = 1'b1; mul_result = 16'h1234;
    @(negedge clk);
    mul_done = 1'b0; mul_result = 16'h0000;
    @(negedge clk);
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL proto_done_in_get_b: result got %h expected 0000", result); end
    n_checks++; if (disp_value !== 16'hFFFF || busy !== 1'b0) begin n_fail++; $display("FAIL proto_state_get_b: disp=%h busy=%b expected ffff 0", disp_value, busy); end
    launch(8'hFF, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL proto_start_seen: got no start expected start within 20 cycles"); end
    repeat (6) @(negedge clk);
    btn = 1'b1;
    repeat (8) @(negedge clk);
    btn = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL proto_press_in_wait: busy got %b expected 1", busy); end
    mul_done = 1'b1; mul_result = 16'hFE01;
    @(negedge clk);
    mul_done = 1'b0; mul_result = 16'h0000;
    n_checks++; if (result !== 16'hFE01) begin n_fail++; $display("FAIL proto_result: got %h expected fe01", result); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL proto_err: got %b expected 0", err); end
    repeat (12) @(negedge clk);
    n_checks++; if (disp_value !== 16'hFE01 || mul_a !== 8'hFF) begin n_fail++; $display("FAIL proto_not_queued: disp=%h mul_a=%h expected fe01 ff", disp_value, mul_a); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int s0;
    press_btn(8'h02);
    launch(8'h03, seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_start_seen: got no start expected start within 20 cycles"); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (result !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_reset: result=%h busy=%b expected 0000 0", result, busy); end
    n_checks++; if (disp_value !== 16'h0003 || mul_a !== 8'h00) begin n_fail++; $display("FAIL rmid_state_a: disp=%h mul_a=%h expected 0003 00", disp_value, mul_a); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    mul_done = 1'b1; mul_result = 16'h0006;
    @(negedge clk);
    mul_done = 1'b0; mul_result = 16'h0000;
    n_checks++; if (result !== 16'h0000 || disp_value !== 16'h0003) begin n_fail++; $display("FAIL rmid_late_done: result=%h disp=%h expected 0000 0003", result, disp_value); end
    repeat (20) @(negedge clk);
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL rmid_no_restart: got %0d starts expected 0", start_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_normal();
    test_timeout();
    test_protocol();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
